// File: rtl/demux_1to4_rr_dispatch.sv
// Flow-controlled 1-to-4 word dispatcher with one-entry channel registers.
// Channel choice is round-robin with burst length and full-channel skipping, or addressed by in_sel.
module demux_1to4_rr_dispatch #(
  parameter int WIDTH     = 16,
  parameter int BURST_LEN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mode,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [1:0]       rr_ptr
);

  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  logic [3:0]       r_valid;
  logic [WIDTH-1:0] r_data [4];
  logic [1:0]       r_ptr;
  logic [CNT_W-1:0] r_cnt;

  logic [3:0]       w_space;
  logic [1:0]       w_idx;
  logic [1:0]       w_rr_sel;
  logic [1:0]       w_sel;
  logic             w_ready;
  logic             w_accept;
  logic [1:0]       w_ptr_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;

  assign w_space = ~r_valid | out_ready;

  // Descending scan so the lowest rotation offset from r_ptr with space wins.
  always_comb begin
    w_idx    = '0;
    w_rr_sel = r_ptr;
    for (int i = 3; i >= 0; i--) begin
      w_idx = r_ptr + 2'(i);
      if (w_space[w_idx]) begin
        w_rr_sel = w_idx;
      end
    end
  end

  always_comb begin
    w_sel   = w_rr_sel;
    w_ready = |w_space;
    if (mode) begin
      w_sel   = in_sel;
      w_ready = w_space[in_sel];
    end
  end

  assign w_accept = in_valid & w_ready;

  always_comb begin
    w_ptr_nxt = r_ptr;
    w_cnt_nxt = r_cnt;
    if (w_accept && !mode) begin
      if (w_sel == r_ptr) begin
        if ((32'(r_cnt) + 1) < BURST_LEN) begin
          w_cnt_nxt = r_cnt + 1'b1;
        end else begin
          w_ptr_nxt = w_sel + 2'd1;
          w_cnt_nxt = '0;
        end
      end else if (BURST_LEN == 1) begin
        w_ptr_nxt = w_sel + 2'd1;
        w_cnt_nxt = '0;
      end else begin
        // Skipped a full channel: the burst restarts on the channel actually used.
        w_ptr_nxt = w_sel;
        w_cnt_nxt = CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      for (int k = 0; k < 4; k++) begin
        r_data[k] <= '0;
      end
    end else begin
      r_ptr <= w_ptr_nxt;
      r_cnt <= w_cnt_nxt;
      for (int k = 0; k < 4; k++) begin
        if (w_accept && (w_sel == 2'(k))) begin
          r_valid[k] <= 1'b1;
          r_data[k]  <= in_data;
        end else if (out_ready[k]) begin
          r_valid[k] <= 1'b0;
        end
      end
    end
  end

  assign in_ready  = w_ready;
  assign out_valid = r_valid;
  assign out_data0 = r_data[0];
  assign out_data1 = r_data[1];
  assign out_data2 = r_data[2];
  assign out_data3 = r_data[3];
  assign rr_ptr    = r_ptr;

endmodule

// File: tb/tb_demux_1to4_rr_dispatch.sv
// Directed bench for demux_1to4_rr_dispatch: one BURST_LEN=1 and one BURST_LEN=3 instance share stimulus.
module tb_demux_1to4_rr_dispatch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        mode;
  logic        in_valid;
  logic [15:0] in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_ready;

  logic        rdy1, rdy3;
  logic [3:0]  ov1, ov3;
  logic [15:0] d1_0, d1_1, d1_2, d1_3;
  logic [15:0] d3_0, d3_1, d3_2, d3_3;
  logic [1:0]  ptr1, ptr3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_1to4_rr_dispatch #(.WIDTH(16), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_sel(in_sel), .out_valid(ov1), .out_ready(out_ready),
    .out_data0(d1_0), .out_data1(d1_1), .out_data2(d1_2), .out_data3(d1_3), .rr_ptr(ptr1)
  );

  demux_1to4_rr_dispatch #(.WIDTH(16), .BURST_LEN(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(rdy3),
    .in_data(in_data), .in_sel(in_sel), .out_valid(ov3), .out_ready(out_ready),
    .out_data0(d3_0), .out_data1(d3_1), .out_data2(d3_2), .out_data3(d3_3), .rr_ptr(ptr3)
  );

  function automatic logic [15:0] d1(input int k);
    case (k)
      0:       return d1_0;
      1:       return d1_1;
      2:       return d1_2;
      default: return d1_3;
    endcase
  endfunction

  function automatic logic [15:0] d3(input int k);
    case (k)
      0:       return d3_0;
      1:       return d3_1;
      2:       return d3_2;
      default: return d3_3;
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int rr3_exp [6];
    rr3_exp = '{0, 0, 1, 1, 1, 2};

    rst_n     = 1'b0;
    mode      = 1'b0;
    in_valid  = 1'b0;
    in_data   = 16'h0;
    in_sel    = 2'd0;
    out_ready = 4'hF;
    #7;
    chk("reset_out_valid", 32'(ov1), 32'h0);
    chk("reset_in_ready", 32'(rdy1), 32'h1);
    chk("reset_rr_ptr", 32'(ptr1), 32'h0);
    chk("reset_data0", 32'(d1_0), 32'h0);
    #1;
    rst_n = 1'b1;

    // Round-robin rotation (BURST_LEN=1) and burst distribution (BURST_LEN=3).
    in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 16'h1000 + 16'(i);
      #1;
      chk("rr_in_ready", 32'(rdy1), 32'h1);
      step();
      chk("rr_valid", 32'(ov1), 32'(4'b0001 << (i % 4)));
      chk("rr_data", 32'(d1(i % 4)), 32'h1000 + 32'(i));
      chk("rr_ptr", 32'(ptr1), 32'((i + 1) % 4));
      if (i < 6) begin
        chk("burst_valid", 32'(ov3), 32'(4'b0001 << (i / 3)));
        chk("burst_data", 32'(d3(i / 3)), 32'h1000 + 32'(i));
        chk("burst_ptr", 32'(ptr3), 32'(rr3_exp[i]));
      end
    end

    // Park a word on channel 1 through addressed mode; rr_ptr must not move.
    mode      = 1'b1;
    in_sel    = 2'd1;
    out_ready = 4'b1101;
    in_data   = 16'h5555;
    step();
    chk("addr_fill_valid", 32'(ov1), 32'h2);
    chk("addr_fill_ptr", 32'(ptr1), 32'h0);
    mode    = 1'b0;
    in_data = 16'h2000;
    step();
    chk("pre_skip_valid", 32'(ov1), 32'h3);
    chk("pre_skip_ptr", 32'(ptr1), 32'h1);
    in_data = 16'hABCD;
    #1;
    chk("skip_in_ready", 32'(rdy1), 32'h1);
    step();
    chk("skip_valid", 32'(ov1), 32'h6);
    chk("skip_data2", 32'(d1_2), 32'hABCD);
    chk("skip_data1_kept", 32'(d1_1), 32'h5555);
    chk("skip_ptr", 32'(ptr1), 32'h3);

    // Asynchronous reset between edges while channels hold data.
    in_valid  = 1'b0;
    out_ready = 4'h0;
    rst_n     = 1'b0;
    #1;
    chk("async_valid", 32'(ov1), 32'h0);
    chk("async_data1", 32'(d1_1), 32'h0);
    chk("async_data2", 32'(d1_2), 32'h0);
    chk("async_ptr", 32'(ptr1), 32'h0);
    chk("async_in_ready", 32'(rdy1), 32'h1);
    #1;
    rst_n = 1'b1;

    // Backpressure: four words fill the channels, the fifth waits.
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = 16'h3000 + 16'(i);
      #1;
      chk("bp_in_ready", 32'(rdy1), 32'h1);
      step();
    end
    chk("bp_full_valid", 32'(ov1), 32'hF);
    chk("bp_full_ptr", 32'(ptr1), 32'h0);
    chk("bp_data0", 32'(d1_0), 32'h3000);
    chk("bp_data3", 32'(d1_3), 32'h3003);
    in_data = 16'h3004;
    #1;
    chk("bp_stall_ready", 32'(rdy1), 32'h0);
    step();
    chk("bp_hold_valid", 32'(ov1), 32'hF);
    chk("bp_hold_data3", 32'(d1_3), 32'h3003);
    chk("bp_hold_ptr", 32'(ptr1), 32'h0);
    out_ready = 4'b1000;
    #1;
    chk("bp_drain_ready", 32'(rdy1), 32'h1);
    step();
    chk("bp_refill_data3", 32'(d1_3), 32'h3004);
    chk("bp_refill_valid", 32'(ov1), 32'hF);
    chk("bp_refill_data2", 32'(d1_2), 32'h3002);
    chk("bp_refill_ptr", 32'(ptr1), 32'h0);

    // Addressed mode: target full and stalled blocks input even with empty channels.
    in_valid  = 1'b0;
    out_ready = 4'b1011;
    step();
    chk("addr_setup_valid", 32'(ov1), 32'h4);
    mode      = 1'b1;
    in_sel    = 2'd2;
    in_valid  = 1'b1;
    out_ready = 4'h0;
    in_data   = 16'h4444;
    #1;
    chk("addr_blocked_ready", 32'(rdy1), 32'h0);
    step();
    chk("addr_blocked_valid", 32'(ov1), 32'h4);
    chk("addr_blocked_data2", 32'(d1_2), 32'h3002);
    chk("addr_blocked_ptr", 32'(ptr1), 32'h0);
    in_sel = 2'd0;
    #1;
    chk("addr_open_ready", 32'(rdy1), 32'h1);
    step();
    chk("addr_open_valid", 32'(ov1), 32'h5);
    chk("addr_open_data0", 32'(d1_0), 32'h4444);
    chk("addr_open_ptr", 32'(ptr1), 32'h0);
    in_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/demux_1to4_rr_dispatch.md
# demux_1to4_rr_dispatch

Sequential dispatcher that distributes a single valid/ready word stream across four output channels through a 1-to-4 demux datapath. Each channel has a one-entry output register, and channel choice follows one of two modes: round-robin with a burst length and skipping of full channels, or explicit addressing through `in_sel`. It sits between a single producer and four parallel consumers, and replaces the free-running `sel` input of the combinational demux with a flow-controlled scheduler.

## Interface
- `WIDTH`, default 16: data word width.
- `BURST_LEN`, default 1: words sent to the current round-robin channel before the pointer rotates. Legal range is 1..16.
- `clk`  in  1  : single clock; all state updates on the rising edge.
- `rst_n`  in  1  : reset, asynchronous and active-low.
- `mode`  in  1  : 0 = round-robin, 1 = addressed by `in_sel`.
- `in_valid`  in  1  : input word present.
- `in_ready`  out  1  : dispatcher accepts the input word this cycle (combinational).
- `in_data`  in  WIDTH  : input word.
- `in_sel`  in  2  : destination channel; used only when `mode`=1.
- `out_valid`  out  4  : bit k set means channel k holds a word.
- `out_ready`  in  4  : bit k set means consumer k takes the word this cycle.
- `out_data0`..`out_data3`  out  WIDTH each  : registered channel words.
- `rr_ptr`  out  2  : current round-robin pointer (status).

## Operation
- Channel space: `space[k] = !out_valid[k] || out_ready[k]`. A channel can be refilled in the same cycle it drains.
- Transfer: accept when `in_valid && in_ready`. On acceptance, `out_data<c>` loads `in_data` and `out_valid[c]` sets.
- Drain: on `out_valid[k] && out_ready[k]` with no refill, `out_valid[k]` clears. `out_data<k>` holds its last value.
- Mode 1, addressed:
  - c = `in_sel`; `in_ready = space[in_sel]`.
  - `rr_ptr` and the burst counter are unchanged.
- Mode 0, round-robin:
  - c = first k in the order `rr_ptr`, `rr_ptr+1`, `rr_ptr+2`, `rr_ptr+3` (mod 4) with `space[k]`=1.
  - `in_ready` = any `space[k]`.
- Internal `cnt` counts words sent to `rr_ptr` in the current burst. It is `ceil(log2(BURST_LEN))` bits wide, minimum 1 bit. Update only on a mode-0 acceptance:
  - c = `rr_ptr` and `cnt+1 < BURST_LEN`: `cnt` increments.
  - c = `rr_ptr` and `cnt+1 = BURST_LEN`: `rr_ptr` becomes c+1 (mod 4, wraps 3 to 0); `cnt` becomes 0.
  - c ≠ `rr_ptr` (skipped a full channel) and `BURST_LEN`=1: `rr_ptr` becomes c+1; `cnt` becomes 0.
  - c ≠ `rr_ptr` and `BURST_LEN`>1: `rr_ptr` becomes c; `cnt` becomes 1.
- Mode switches take effect on the next evaluated cycle. `rr_ptr` and `cnt` are retained across a switch.
- No word is ever dropped or duplicated. `in_ready` never depends on `in_valid`.
- `in_sel` is ignored when `mode`=0.

## Timing
- Reset values (asynchronous assert):
  - `out_valid` = 4'b0000.
  - `out_data0`..`out_data3` = 0.
  - `rr_ptr` = 0 and `cnt` = 0.
  - `in_ready` = 1 after reset, since all channels are empty.
- Reset deassertion is synchronised externally. The first acceptance can occur on the first edge after `rst_n` rises.
- Latency: a word accepted at edge N is visible on `out_valid[c]`/`out_data<c>` after edge N and stays stable until an edge at which `out_ready[c]`=1.
- Throughput: one word per cycle total, including continuous traffic to one channel whose `out_ready` is held high.
- All four channels full with no `out_ready`: `in_ready`=0 and no state changes.
- Reset asserted mid-operation: held words are discarded, and all outputs return to their reset values immediately (not at a clock edge).

## Test plan
- Reset and round-robin rotation: `BURST_LEN`=1, mode 0, all `out_ready`=1, words 0x1000..0x1007 → channels 0,1,2,3,0,1,2,3 on consecutive cycles; `rr_ptr` sequence 1,2,3,0,…
- Burst: `BURST_LEN`=3, mode 0, all ready, 6 words → channels 0,0,0,1,1,1; `rr_ptr` = 2 afterwards.
- Skip full channel: `BURST_LEN`=1, channel 1 full with `out_ready[1]`=0, `rr_ptr`=1, word 0xABCD → lands on channel 2; `rr_ptr`=3; channel 1 data unchanged.
- Backpressure: all `out_ready`=0, 5 words offered → 4 accepted (one per channel), then `in_ready`=0. Raise `out_ready[3]` for one cycle → the 5th word enters channel 3 in that same cycle.
- Addressed mode: mode 1, `in_sel`=2 with channel 2 full and not ready → `in_ready`=0 even though other channels are empty; `rr_ptr` is unchanged.
- Async reset: assert `rst_n`=0 between edges while channels hold data → `out_valid`=0 and all `out_data`=0 before the next edge.
